// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word loads/stores on a local data memory
// with MEM_LATENCY wait states, MEM/WB pipeline register and MEM-side forwarding taps.
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        EXMEMRegWrite,
    input  logic        EXMEMMemtoReg,
    input  logic        EXMEMMemRead,
    input  logic        EXMEMMemWrite,
    input  logic [31:0] EXMEMReadAddress,
    input  logic [31:0] EXMEMWriteData,
    input  logic [4:0]  EXMEMDst,
    output logic        MemStall,
    output logic [31:0] MEMForwarding,
    output logic [4:0]  MEMDst,
    output logic        MEMRegWrite,
    output logic        MEMWBRegWrite,
    output logic        MEMWBMemtoReg,
    output logic [31:0] MEMWBReadData,
    output logic [31:0] MEMWBALUResult,
    output logic [4:0]  MEMWBDst,
    output logic        MemMisalign
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            stall;
    logic            complete;
    logic            access;
    logic            misaligned;
    logic [AW-1:0]   idx;
    logic [31:0]     mem [DEPTH];

    logic            regWrite_q, memtoReg_q, misalign_q;
    logic [31:0]     readData_q, aluResult_q;
    logic [4:0]      dst_q;

    assign access     = EXMEMMemRead | EXMEMMemWrite;
    assign misaligned = EXMEMReadAddress[1:0] != 2'b00;
    assign idx        = EXMEMReadAddress[AW+1:2];

    assign MEMForwarding = EXMEMReadAddress;
    assign MEMDst        = EXMEMDst;
    assign MEMRegWrite   = EXMEMRegWrite;
    assign MemStall      = stall;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (MEM_LATENCY == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = CW'(MEM_LATENCY);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q > CW'(1)) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    complete = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory is not reset; a reset during WAIT simply never reaches the commit.
    always_ff @(posedge clock) begin
        if (!reset && complete && access && EXMEMMemWrite && !misaligned) begin
            mem[idx] <= EXMEMWriteData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regWrite_q  <= 1'b0;
            memtoReg_q  <= 1'b0;
            readData_q  <= '0;
            aluResult_q <= '0;
            dst_q       <= '0;
            misalign_q  <= 1'b0;
        end else if (stall) begin
            regWrite_q <= 1'b0;
            memtoReg_q <= 1'b0;
        end else begin
            regWrite_q  <= EXMEMRegWrite;
            memtoReg_q  <= EXMEMMemtoReg;
            aluResult_q <= EXMEMReadAddress;
            dst_q       <= EXMEMDst;
            readData_q  <= (complete && EXMEMMemRead && !misaligned) ? mem[idx] : 32'h0;
            if (complete && access && misaligned) begin
                misalign_q <= 1'b1;
            end
        end
    end

    assign MEMWBRegWrite  = regWrite_q;
    assign MEMWBMemtoReg  = memtoReg_q;
    assign MEMWBReadData  = readData_q;
    assign MEMWBALUResult = aluResult_q;
    assign MEMWBDst       = dst_q;
    assign MemMisalign    = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (DEPTH=256, MEM_LATENCY=2): ALU pass-through, load/store
// latency, misalignment, reset abort, read-before-write and address aliasing.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        EXMEMRegWrite, EXMEMMemtoReg, EXMEMMemRead, EXMEMMemWrite;
    logic [31:0] EXMEMReadAddress, EXMEMWriteData;
    logic [4:0]  EXMEMDst;
    logic        MemStall, MEMRegWrite, MEMWBRegWrite, MEMWBMemtoReg, MemMisalign;
    logic [31:0] MEMForwarding, MEMWBReadData, MEMWBALUResult;
    logic [4:0]  MEMDst, MEMWBDst;

    int total = 0;
    int bad   = 0;

    mem_stage #(.DEPTH(256), .MEM_LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .EXMEMRegWrite(EXMEMRegWrite), .EXMEMMemtoReg(EXMEMMemtoReg),
        .EXMEMMemRead(EXMEMMemRead), .EXMEMMemWrite(EXMEMMemWrite),
        .EXMEMReadAddress(EXMEMReadAddress), .EXMEMWriteData(EXMEMWriteData),
        .EXMEMDst(EXMEMDst), .MemStall(MemStall), .MEMForwarding(MEMForwarding),
        .MEMDst(MEMDst), .MEMRegWrite(MEMRegWrite), .MEMWBRegWrite(MEMWBRegWrite),
        .MEMWBMemtoReg(MEMWBMemtoReg), .MEMWBReadData(MEMWBReadData),
        .MEMWBALUResult(MEMWBALUResult), .MEMWBDst(MEMWBDst), .MemMisalign(MemMisalign)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] dst);
        EXMEMRegWrite    = rw;
        EXMEMMemtoReg    = rd;
        EXMEMMemRead     = rd;
        EXMEMMemWrite    = wr;
        EXMEMReadAddress = addr;
        EXMEMWriteData   = data;
        EXMEMDst         = dst;
    endtask

    // Drives one memory access from a negedge, counts stall cycles until completion,
    // and returns at the negedge after the completing edge.
    task automatic doAccess(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] dst);
        int stalls = 0;
        bit done = 0;
        applyStimulus(rd, rd, wr, addr, data, dst);
        for (int i = 0; i < 10 && !done; i++) begin
            #1;
            checkOutput({tag, ".fwd"}, MEMForwarding, addr);
            if (MemStall) begin
                stalls++;
                @(posedge clock);
                @(negedge clock);
                checkOutput({tag, ".bubble"}, {31'b0, MEMWBRegWrite}, 32'h0);
            end else begin
                done = 1;
            end
        end
        checkOutput({tag, ".done"}, {31'b0, done}, 32'h1);
        checkOutput({tag, ".stalls"}, stalls, 32'd2);
        @(posedge clock);
        @(negedge clock);
        checkOutput({tag, ".regwrite"}, {31'b0, MEMWBRegWrite}, {31'b0, rd});
        checkOutput({tag, ".dst"}, {27'b0, MEMWBDst}, {27'b0, dst});
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("rst.regwrite", {31'b0, MEMWBRegWrite}, 32'h0);
        checkOutput("rst.memtoreg", {31'b0, MEMWBMemtoReg}, 32'h0);
        checkOutput("rst.readdata", MEMWBReadData, 32'h0);
        checkOutput("rst.alu", MEMWBALUResult, 32'h0);
        checkOutput("rst.dst", {27'b0, MEMWBDst}, 32'h0);
        checkOutput("rst.stall", {31'b0, MemStall}, 32'h0);
        checkOutput("rst.misalign", {31'b0, MemMisalign}, 32'h0);
        reset = 1'b0;

        // ALU op passes through in one cycle
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_002A, 32'h0, 5'd5);
        #1;
        checkOutput("alu.stall", {31'b0, MemStall}, 32'h0);
        checkOutput("alu.fwddst", {27'b0, MEMDst}, 32'd5);
        checkOutput("alu.fwdrw", {31'b0, MEMRegWrite}, 32'h1);
        @(posedge clock);
        @(negedge clock);
        checkOutput("alu.result", MEMWBALUResult, 32'h2A);
        checkOutput("alu.dst", {27'b0, MEMWBDst}, 32'd5);
        checkOutput("alu.regwrite", {31'b0, MEMWBRegWrite}, 32'h1);
        checkOutput("alu.readdata", MEMWBReadData, 32'h0);

        // Store then load at 0x10
        doAccess("st10", 1'b0, 1'b1, 32'h10, 32'h1122_3344, 5'd0);
        doAccess("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 5'd7);
        checkOutput("ld10.data", MEMWBReadData, 32'h1122_3344);
        checkOutput("ld10.memtoreg", {31'b0, MEMWBMemtoReg}, 32'h1);

        // Misaligned store is dropped, flag sticks
        doAccess("st13", 1'b0, 1'b1, 32'h13, 32'h9999_9999, 5'd0);
        checkOutput("st13.misalign", {31'b0, MemMisalign}, 32'h1);
        doAccess("ld13", 1'b1, 1'b0, 32'h13, 32'h0, 5'd3);
        checkOutput("ld13.data", MEMWBReadData, 32'h0);
        doAccess("ld10b", 1'b1, 1'b0, 32'h10, 32'h0, 5'd8);
        checkOutput("ld10b.data", MEMWBReadData, 32'h1122_3344);
        checkOutput("ld10b.misalign", {31'b0, MemMisalign}, 32'h1);

        // Reset in second stall cycle aborts the store
        doAccess("st20", 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 5'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 5'd0);
        #1;
        checkOutput("abort.stall1", {31'b0, MemStall}, 32'h1);
        @(posedge clock);
        @(negedge clock);
        checkOutput("abort.stall2", {31'b0, MemStall}, 32'h1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        checkOutput("abort.misalign", {31'b0, MemMisalign}, 32'h0);
        doAccess("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 5'd9);
        checkOutput("ld20.data", MEMWBReadData, 32'hCAFE_F00D);

        // Read+write returns old data; 0x440 aliases 0x40
        doAccess("st40", 1'b0, 1'b1, 32'h40, 32'hA5A5_A5A5, 5'd0);
        doAccess("rw40", 1'b1, 1'b1, 32'h40, 32'h5A5A_5A5A, 5'd10);
        checkOutput("rw40.data", MEMWBReadData, 32'hA5A5_A5A5);
        doAccess("ld440", 1'b1, 1'b0, 32'h440, 32'h0, 5'd11);
        checkOutput("ld440.data", MEMWBReadData, 32'h5A5A_5A5A);
        checkOutput("ld440.alu", MEMWBALUResult, 32'h440);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
